// File: rtl/xx02_g_mm_arbiter.sv
// xx02_g_mm_arbiter
//   Shares the xx02 MM decoder port between the host master (m0) and the
//   debug/BIST master (m1) with round-robin grants. Only one read can be
//   outstanding. Each response is routed back to the master that issued it.
//   A read that gets no response within TIMEOUT cycles returns TO_DATA.
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   mN_req_wr/rd, mN_addr, mN_wdata master N request (held until mN_gnt)
//   mN_gnt, mN_rdata, mN_rdata_v    grant pulse, read data, read strobe
//   oMM_WR_EN/RD_EN/ADDR/WR_DATA    command to the decoder (registered)
//   iMM_RD_DATA, iMM_RD_DATA_V      decoder read return
//   clr_err                         clears timeout_err and stray_cnt
//   timeout_err                     sticky read-timeout flag
//   stray_cnt                       saturating count of unexpected valids
module xx02_g_mm_arbiter #(
   parameter int unsigned   TIMEOUT = 64,
   parameter logic [63:0]   TO_DATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req_wr,
   input  logic        m0_req_rd,
   input  logic [13:0] m0_addr,
   input  logic [63:0] m0_wdata,
   output logic        m0_gnt,
   output logic [63:0] m0_rdata,
   output logic        m0_rdata_v,
   input  logic        m1_req_wr,
   input  logic        m1_req_rd,
   input  logic [13:0] m1_addr,
   input  logic [63:0] m1_wdata,
   output logic        m1_gnt,
   output logic [63:0] m1_rdata,
   output logic        m1_rdata_v,
   output logic        oMM_WR_EN,
   output logic        oMM_RD_EN,
   output logic [13:0] oMM_ADDR,
   output logic [63:0] oMM_WR_DATA,
   input  logic [63:0] iMM_RD_DATA,
   input  logic        iMM_RD_DATA_V,
   input  logic        clr_err,
   output logic        timeout_err,
   output logic [7:0]  stray_cnt
);

   typedef enum logic [1:0] {IDLE, WR_GAP, RD_WAIT} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q;
   logic        last_gnt_q;
   logic        owner_q;
   logic [7:0]  cnt_q;
   logic [1:0]  gnt_q;
   logic [1:0]  rdv_q;
   logic [63:0] rdata_q [2];
   logic        wr_en_q;
   logic        rd_en_q;
   logic [13:0] addr_q;
   logic [63:0] wdata_q;
   logic        terr_q;
   logic [7:0]  stray_q;

   logic        req0, req1;
   logic        win_vld, win;
   logic        win_wr;
   logic [13:0] win_addr;
   logic [63:0] win_wdata;
   logic        stray_hit;

   // Winner selection: a lone requester wins; on a tie the master that did
   // not win last time gets the port.
   always_comb begin
      req0      = m0_req_wr | m0_req_rd;
      req1      = m1_req_wr | m1_req_rd;
      win_vld   = req0 | req1;
      win       = req1 & (~req0 | ~last_gnt_q);
      win_wr    = win ? m1_req_wr : m0_req_wr;
      win_addr  = win ? m1_addr   : m0_addr;
      win_wdata = win ? m1_wdata  : m0_wdata;
      stray_hit = iMM_RD_DATA_V & (state_q != RD_WAIT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
         owner_q    <= 1'b0;
         cnt_q      <= '0;
         gnt_q      <= '0;
         rdv_q      <= '0;
         rdata_q[0] <= '0;
         rdata_q[1] <= '0;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         terr_q     <= 1'b0;
         stray_q    <= '0;
      end else begin
         gnt_q   <= '0;
         rdv_q   <= '0;
         wr_en_q <= 1'b0;
         rd_en_q <= 1'b0;

         // Clear first so a same-cycle set below takes precedence.
         if (clr_err) terr_q <= 1'b0;

         if (stray_hit) begin
            if (clr_err)               stray_q <= 8'd1;
            else if (stray_q != 8'hFF) stray_q <= stray_q + 8'd1;
         end else if (clr_err) begin
            stray_q <= '0;
         end

         unique case (state_q)
            IDLE: begin
               if (win_vld) begin
                  addr_q     <= win_addr;
                  wdata_q    <= win_wdata;
                  gnt_q[win] <= 1'b1;
                  owner_q    <= win;
                  last_gnt_q <= win;
                  // A write takes priority over a simultaneous read from
                  // the same master; the held read is arbitrated later.
                  if (win_wr) begin
                     wr_en_q <= 1'b1;
                     state_q <= WR_GAP;
                  end else begin
                     rd_en_q <= 1'b1;
                     cnt_q   <= '0;
                     state_q <= RD_WAIT;
                  end
               end
            end
            WR_GAP: state_q <= IDLE;
            RD_WAIT: begin
               if (iMM_RD_DATA_V) begin
                  rdata_q[owner_q] <= iMM_RD_DATA;
                  rdv_q[owner_q]   <= 1'b1;
                  state_q          <= IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  rdata_q[owner_q] <= TO_DATA;
                  rdv_q[owner_q]   <= 1'b1;
                  terr_q           <= 1'b1;
                  state_q          <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m0_gnt      = gnt_q[0];
   assign m1_gnt      = gnt_q[1];
   assign m0_rdata_v  = rdv_q[0];
   assign m1_rdata_v  = rdv_q[1];
   assign m0_rdata    = rdata_q[0];
   assign m1_rdata    = rdata_q[1];
   assign oMM_WR_EN   = wr_en_q;
   assign oMM_RD_EN   = rd_en_q;
   assign oMM_ADDR    = addr_q;
   assign oMM_WR_DATA = wdata_q;
   assign timeout_err = terr_q;
   assign stray_cnt   = stray_q;

endmodule

// File: tb/tb_xx02_g_mm_arbiter.sv
// Directed testbench for xx02_g_mm_arbiter (TIMEOUT overridden to 16).
module tb_xx02_g_mm_arbiter;

   localparam logic [63:0] TO_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req_wr, m0_req_rd, m1_req_wr, m1_req_rd;
   logic [13:0] m0_addr, m1_addr;
   logic [63:0] m0_wdata, m1_wdata;
   logic        m0_gnt, m1_gnt, m0_rdata_v, m1_rdata_v;
   logic [63:0] m0_rdata, m1_rdata;
   logic        oMM_WR_EN, oMM_RD_EN;
   logic [13:0] oMM_ADDR;
   logic [63:0] oMM_WR_DATA;
   logic [63:0] iMM_RD_DATA;
   logic        iMM_RD_DATA_V;
   logic        clr_err;
   logic        timeout_err;
   logic [7:0]  stray_cnt;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   xx02_g_mm_arbiter #(.TIMEOUT(16), .TO_DATA(TO_DATA)) dut (
      .clk(clk), .rst(rst),
      .m0_req_wr(m0_req_wr), .m0_req_rd(m0_req_rd), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
      .m0_rdata_v(m0_rdata_v),
      .m1_req_wr(m1_req_wr), .m1_req_rd(m1_req_rd), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
      .m1_rdata_v(m1_rdata_v),
      .oMM_WR_EN(oMM_WR_EN), .oMM_RD_EN(oMM_RD_EN), .oMM_ADDR(oMM_ADDR),
      .oMM_WR_DATA(oMM_WR_DATA), .iMM_RD_DATA(iMM_RD_DATA),
      .iMM_RD_DATA_V(iMM_RD_DATA_V), .clr_err(clr_err),
      .timeout_err(timeout_err), .stray_cnt(stray_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_strobes(input string tag, input logic g0, input logic g1,
                              input logic wr, input logic rd);
      chk({tag, ".m0_gnt"}, 64'(m0_gnt), 64'(g0));
      chk({tag, ".m1_gnt"}, 64'(m1_gnt), 64'(g1));
      chk({tag, ".wr_en"},  64'(oMM_WR_EN), 64'(wr));
      chk({tag, ".rd_en"},  64'(oMM_RD_EN), 64'(rd));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk_strobes(tag, 1'b0, 1'b0, 1'b0, 1'b0);
      chk({tag, ".m0_rdata_v"}, 64'(m0_rdata_v), 64'd0);
      chk({tag, ".m1_rdata_v"}, 64'(m1_rdata_v), 64'd0);
      chk({tag, ".m0_rdata"}, m0_rdata, 64'd0);
      chk({tag, ".m1_rdata"}, m1_rdata, 64'd0);
      chk({tag, ".addr"}, 64'(oMM_ADDR), 64'd0);
      chk({tag, ".wdata"}, oMM_WR_DATA, 64'd0);
      chk({tag, ".terr"}, 64'(timeout_err), 64'd0);
      chk({tag, ".stray"}, 64'(stray_cnt), 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      m0_req_wr = 0; m0_req_rd = 0; m1_req_wr = 0; m1_req_rd = 0;
      m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
      iMM_RD_DATA = '0; iMM_RD_DATA_V = 0; clr_err = 0;
      tick(); tick();
      chk_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // Contention: both hold writes; grants alternate m0, m1, m0.
      m0_req_wr = 1; m0_addr = 14'h0001; m0_wdata = 64'hA0;
      m1_req_wr = 1; m1_addr = 14'h0402; m1_wdata = 64'hB1;
      tick();
      chk_strobes("cont0", 1, 0, 1, 0);
      chk("cont0.addr", 64'(oMM_ADDR), 64'h0001);
      chk("cont0.data", oMM_WR_DATA, 64'hA0);
      tick();
      chk_strobes("cont0gap", 0, 0, 0, 0);
      tick();
      chk_strobes("cont1", 0, 1, 1, 0);
      chk("cont1.addr", 64'(oMM_ADDR), 64'h0402);
      chk("cont1.data", oMM_WR_DATA, 64'hB1);
      tick();
      chk_strobes("cont1gap", 0, 0, 0, 0);
      tick();
      chk_strobes("cont2", 1, 0, 1, 0);
      chk("cont2.addr", 64'(oMM_ADDR), 64'h0001);
      m0_req_wr = 0; m1_req_wr = 0;
      tick(); tick();
      chk_strobes("cont_idle", 0, 0, 0, 0);

      // Single write from m0.
      m0_req_wr = 1; m0_addr = 14'h0010; m0_wdata = 64'h1122_3344_5566_7788;
      tick();
      chk_strobes("wr", 1, 0, 1, 0);
      chk("wr.addr", 64'(oMM_ADDR), 64'h0010);
      chk("wr.data", oMM_WR_DATA, 64'h1122_3344_5566_7788);
      chk("wr.m1_rdata_v", 64'(m1_rdata_v), 64'd0);
      m0_req_wr = 0;
      tick();
      chk_strobes("wr_gap", 0, 0, 0, 0);
      tick();

      // Read routing to m1; an m0 write held during RD_WAIT waits.
      m1_req_rd = 1; m1_addr = 14'h0400;
      tick();
      chk_strobes("rd1", 0, 1, 0, 1);
      chk("rd1.addr", 64'(oMM_ADDR), 64'h0400);
      m1_req_rd = 0;
      m0_req_wr = 1; m0_addr = 14'h0020; m0_wdata = 64'h55;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk_strobes("rd1_wait", 0, 0, 0, 0);
      end
      tick();
      iMM_RD_DATA = 64'hCAFE; iMM_RD_DATA_V = 1;
      tick();
      iMM_RD_DATA_V = 0; iMM_RD_DATA = '0;
      chk("rd1.m1_rdata_v", 64'(m1_rdata_v), 64'd1);
      chk("rd1.m1_rdata", m1_rdata, 64'hCAFE);
      chk("rd1.m0_rdata_v", 64'(m0_rdata_v), 64'd0);
      chk("rd1.m0_gnt_late", 64'(m0_gnt), 64'd0);
      tick();
      chk_strobes("rd1_m0wr", 1, 0, 1, 0);
      chk("rd1_m0wr.addr", 64'(oMM_ADDR), 64'h0020);
      chk("rd1.m1_rdata_v_off", 64'(m1_rdata_v), 64'd0);
      m0_req_wr = 0;
      tick();
      chk("rd1.m1_rdata_hold", m1_rdata, 64'hCAFE);
      tick();

      // Timeout on an m0 read.
      m0_req_rd = 1; m0_addr = 14'h0030;
      tick();
      chk_strobes("to_issue", 1, 0, 0, 1);
      m0_req_rd = 0;
      for (int i = 1; i <= 15; i++) begin
         tick();
         chk("to_wait.m0_rdata_v", 64'(m0_rdata_v), 64'd0);
      end
      tick();
      chk("to.m0_rdata_v", 64'(m0_rdata_v), 64'd1);
      chk("to.m0_rdata", m0_rdata, TO_DATA);
      chk("to.m1_rdata_v", 64'(m1_rdata_v), 64'd0);
      chk("to.terr", 64'(timeout_err), 64'd1);
      tick(); tick(); tick();
      iMM_RD_DATA = 64'h9999; iMM_RD_DATA_V = 1;
      tick();
      iMM_RD_DATA_V = 0;
      chk("late.stray", 64'(stray_cnt), 64'd1);
      chk("late.m0_rdata_v", 64'(m0_rdata_v), 64'd0);
      chk("late.m0_rdata", m0_rdata, TO_DATA);
      clr_err = 1;
      tick();
      clr_err = 0;
      chk("clr.terr", 64'(timeout_err), 64'd0);
      chk("clr.stray", 64'(stray_cnt), 64'd0);

      // Valid arriving exactly on the timeout cycle wins.
      m1_req_rd = 1; m1_addr = 14'h0500;
      tick();
      chk_strobes("edge_issue", 0, 1, 0, 1);
      m1_req_rd = 0;
      for (int i = 1; i <= 14; i++) tick();
      tick();
      iMM_RD_DATA = 64'h1234; iMM_RD_DATA_V = 1;
      tick();
      iMM_RD_DATA_V = 0;
      chk("edge.m1_rdata_v", 64'(m1_rdata_v), 64'd1);
      chk("edge.m1_rdata", m1_rdata, 64'h1234);
      chk("edge.terr", 64'(timeout_err), 64'd0);
      chk("edge.stray", 64'(stray_cnt), 64'd0);

      // Stray with clr_err in the same cycle: increment wins.
      iMM_RD_DATA_V = 1; clr_err = 1;
      tick();
      iMM_RD_DATA_V = 0; clr_err = 0;
      chk("clr_inc.stray", 64'(stray_cnt), 64'd1);

      // Saturation at 255.
      iMM_RD_DATA_V = 1;
      for (int i = 0; i < 260; i++) tick();
      iMM_RD_DATA_V = 0;
      chk("sat.stray", 64'(stray_cnt), 64'd255);
      tick();
      chk("sat_hold.stray", 64'(stray_cnt), 64'd255);
      clr_err = 1;
      tick();
      clr_err = 0;
      chk("sat_clr.stray", 64'(stray_cnt), 64'd0);

      // Reset during RD_WAIT abandons the read; late valid is stray.
      m0_req_rd = 1; m0_addr = 14'h0040;
      tick();
      chk_strobes("rst_issue", 1, 0, 0, 1);
      m0_req_rd = 0;
      tick(); tick();
      rst = 1;
      tick();
      rst = 0;
      chk_reset_outputs("rst_mid");
      iMM_RD_DATA = 64'h7777; iMM_RD_DATA_V = 1;
      tick();
      iMM_RD_DATA_V = 0;
      chk("rst_late.m0_rdata_v", 64'(m0_rdata_v), 64'd0);
      chk("rst_late.m0_rdata", m0_rdata, 64'd0);
      chk("rst_late.stray", 64'(stray_cnt), 64'd1);
      m0_req_wr = 1; m0_addr = 14'h0003; m1_req_wr = 1; m1_addr = 14'h0404;
      tick();
      chk_strobes("rst_tie", 1, 0, 1, 0);
      chk("rst_tie.addr", 64'(oMM_ADDR), 64'h0003);
      m0_req_wr = 0; m1_req_wr = 0;
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/xx02_g_mm_arbiter.md
# xx02_g_mm_arbiter

Two-master arbiter in front of the xx02 MM address decoder. It shares the decoder's single MM port between the host MM master (m0) and the internal debug/BIST master (m1) using round-robin grants. It allows one outstanding read and routes each read response back to the master that issued it. A read that gets no response within a bounded number of cycles returns a timeout pattern, so a master never hangs.

## Interface
Parameters:
- TIMEOUT, 64: cycles to wait in RD_WAIT for iMM_RD_DATA_V (legal range 4..255).
- TO_DATA, 64'hDEAD_BEEF_DEAD_BEEF: read data returned on timeout.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- mN_req_wr / mN_req_rd  in  1  write/read request from master N (N=0,1); held until mN_gnt is seen.
- mN_addr  in  14  request address.
- mN_wdata  in  64  write data.
- mN_gnt  out  1  one-cycle grant pulse; the request was issued.
- mN_rdata  out  64  read response data.
- mN_rdata_v  out  1  one-cycle read response strobe.
- oMM_WR_EN / oMM_RD_EN  out  1  one-cycle strobes to the decoder.
- oMM_ADDR  out  14, oMM_WR_DATA  out  64: command to the decoder.
- iMM_RD_DATA  in  64, iMM_RD_DATA_V  in  1: decoder read return.
- clr_err  in  1  clears timeout_err and stray_cnt.
- timeout_err  out  1  sticky; set on any read timeout.
- stray_cnt  out  8  saturating count of iMM_RD_DATA_V seen outside RD_WAIT.

## Operation
- State machine (registered state) with states IDLE, WR_GAP and RD_WAIT.
- IDLE:
  - A master is requesting when req_wr | req_rd is high.
  - If only one master requests, that master wins.
  - If both request, the master other than last_gnt wins. last_gnt resets to 1, so m0 wins the first tie.
  - On the winning edge the arbiter registers oMM_ADDR/oMM_WR_DATA from the winner and pulses mN_gnt. It also pulses oMM_WR_EN (write) or oMM_RD_EN (read), records owner, and updates last_gnt.
  - A write moves to WR_GAP. A read moves to RD_WAIT and clears the timeout counter.
- If req_wr and req_rd are both high from the same master, the write is issued and the read is ignored. The master keeps req_rd held and it is arbitrated later.
- WR_GAP: strobes and grant are low, requests are ignored, and the next state is IDLE. This gives the master one cycle to drop its request.
- RD_WAIT:
  - Requests are ignored and the counter increments each cycle.
  - When iMM_RD_DATA_V=1, mN_rdata of the owner is loaded with iMM_RD_DATA, mN_rdata_v of the owner pulses, and the next state is IDLE.
  - When the counter reaches TIMEOUT-1 without a valid, the owner gets TO_DATA with an rdata_v pulse, timeout_err is set, and the next state is IDLE.
  - If valid and timeout occur in the same cycle, the valid wins: real data is returned and timeout_err is not set.
- iMM_RD_DATA_V seen in IDLE or WR_GAP (for example a late response after a timeout) is discarded and increments stray_cnt. stray_cnt saturates at 255.
- clr_err=1 clears timeout_err and stray_cnt. If a set/increment happens in the same cycle as clr_err, the set/increment wins (result is 1 for both).
- The non-owner's mN_rdata_v is never asserted. mN_rdata holds its last value between responses.
- Reset mid-operation: state goes to IDLE and any outstanding read is abandoned with no rdata_v. A later iMM_RD_DATA_V counts as stray.

## Timing
- Reset values:
  - All strobes, gnt, rdata_v, timeout_err and stray_cnt are 0.
  - oMM_ADDR, oMM_WR_DATA and mN_rdata are 0.
  - state=IDLE, last_gnt=1, counter=0.
- Request high before edge k while in IDLE: mN_gnt and the oMM strobe are high in cycle k+1, for exactly one cycle.
- Write throughput is one write per 2 cycles (issue + WR_GAP).
- Read response: iMM_RD_DATA_V in cycle t produces mN_rdata_v in cycle t+1. The arbiter is IDLE in t+1 and can issue in t+2.
- Timeout: a read issued in cycle k+1 with no valid returns TO_DATA with rdata_v in cycle k+1+TIMEOUT.
- Masters must drop or change the request in the cycle after gnt. A request still held in IDLE is treated as a new request.

## Test plan
- Single write: m0_req_wr, addr 14'h0010, data 64'h1122_3344_5566_7788 -> one-cycle oMM_WR_EN with the same address/data, m0_gnt pulse coincident, m1 outputs quiet.
- Contention: m0 and m1 both hold req_wr (addresses 14'h0001 and 14'h0402) from reset -> grants alternate m0, m1, m0… with oMM_WR_EN every 2 cycles and addresses matching each grant.
- Read routing: m1 reads 14'h0400, bench returns iMM_RD_DATA 64'hCAFE with valid 5 cycles after oMM_RD_EN -> m1_rdata=64'hCAFE, m1_rdata_v one cycle later, m0_rdata_v=0. An m0 request held during RD_WAIT is granted only afterwards.
- Timeout: TIMEOUT=16, m0 reads and no valid arrives -> m0_rdata=TO_DATA with rdata_v 16 cycles after oMM_RD_EN, timeout_err=1. A valid injected 3 cycles later is dropped and stray_cnt=1. clr_err -> both return to 0.
- Valid exactly at the timeout cycle -> real data returned, timeout_err stays 0.
- rst asserted during RD_WAIT, then a valid arrives -> no rdata_v, all outputs at reset values, stray_cnt=1. The next m0/m1 tie after reset goes to m0.
